prog_sequencer: RTL

- Run controller in front of the basic processor. Launches programs 0..NUM_PROGS-1 back to back.
- For each program it drives the processor's start/init and the program selector, then waits for the processor's halt.
- Records a per-program cycle count and a per-program done flag. Raises all_done when every program has finished.
- Sits between the testbench/top-level go signal and the processor's start, halt and program-select inputs.

---
 rtl/prog_seq_pkg.sv | 28 ++
 rtl/sat_counter.sv | 51 +++++
 rtl/prog_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_seq_pkg.sv
// -----------------------------------------------------------------------------
// prog_seq_pkg
//   Shared types and default constants for the program sequencer.
//   state_t        : sequencer FSM states.
//   DEF_*          : default parameter values used by prog_sequencer.
//   seq_is_busy()  : true in every state that belongs to an active launch.
// -----------------------------------------------------------------------------
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    RECORD = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned DEF_NUM_PROGS  = 3;
  localparam int unsigned DEF_START_HOLD = 2;
  localparam int unsigned DEF_CYC_W      = 16;
  localparam int unsigned DEF_WDOG_LIMIT = 4096;

  function automatic logic seq_is_busy(input state_t s);
    return (s == LAUNCH) || (s == ARM) || (s == RUN) || (s == RECORD);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear that sticks at all-ones instead of
//   wrapping.
//   Ports:
//     clk   in  1  clock, posedge
//     rst_n in  1  asynchronous active-low reset (count -> 0)
//     clr   in  1  synchronous clear, wins over en
//     en    in  1  increment enable
//     cnt   out W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}}) begin
      return v;
    end
    return v + W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//   Run controller in front of the processor. On go it launches programs
//   0..NUM_PROGS-1 back to back: pulses cpu_start for START_HOLD cycles with
//   prog_sel set, waits for the processor to leave halt, then waits for halt
//   again, recording the cycle count and a done flag for each program.
//
//   Optional watchdog: define PROG_SEQ_WDOG_EN. A program still running after
//   WDOG_LIMIT cycles in ARM+RUN is recorded with count WDOG_LIMIT, its done
//   flag left clear, and the sticky timeout output set. Without the macro the
//   watchdog is absent and timeout is tied low.
//
//   Ports:
//     CLK        in  1                  clock, posedge
//     reset_n    in  1                  asynchronous active-low reset
//     go         in  1                  start the sequence (IDLE/DONE only)
//     cpu_halt   in  1                  processor halted
//     cpu_start  out 1                  processor init, high during LAUNCH
//     prog_sel   out $clog2(NUM_PROGS)  program being launched/run
//     busy       out 1                  LAUNCH/ARM/RUN/RECORD
//     done_flags out NUM_PROGS          bit i: program i halted
//     all_done   out 1                  high in DONE
//     cycle_cts  out NUM_PROGS*CYC_W    program i at [i*CYC_W +: CYC_W]
//     timeout    out 1                  watchdog fired (sticky)
// -----------------------------------------------------------------------------
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = DEF_NUM_PROGS,
  parameter int unsigned START_HOLD = DEF_START_HOLD,
  parameter int unsigned CYC_W      = DEF_CYC_W,
  parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         go,
  input  logic                         cpu_halt,
  output logic                         cpu_start,
  output logic [$clog2(NUM_PROGS)-1:0] prog_sel,
  output logic                         busy,
  output logic [NUM_PROGS-1:0]         done_flags,
  output logic                         all_done,
  output logic [NUM_PROGS*CYC_W-1:0]   cycle_cts,
  output logic                         timeout
);

  localparam int unsigned PS_W   = $clog2(NUM_PROGS);
  localparam int unsigned HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  if ((NUM_PROGS < 2) || (NUM_PROGS > 4) || (START_HOLD < 1) ||
      (CYC_W < 1) || (WDOG_LIMIT < 1)) begin : g_param_chk
    $error("prog_sequencer: parameter out of range");
  end

  state_t                     state_q,      state_d;
  logic [HOLD_W-1:0]          hold_ct_q,    hold_ct_d;
  logic [PS_W-1:0]            prog_sel_q,   prog_sel_d;
  logic [NUM_PROGS-1:0]       done_flags_q, done_flags_d;
  logic [NUM_PROGS*CYC_W-1:0] cycle_cts_q,  cycle_cts_d;
  logic                       cpu_start_q,  cpu_start_d;
  logic                       busy_q,       busy_d;
  logic                       all_done_q,   all_done_d;

  logic                       run_en;
  logic                       run_clr;
  logic [CYC_W-1:0]           run_cnt;

  // ARM cycles count toward the program, so both ARM and RUN enable.
  assign run_en = (state_q == ARM) || (state_q == RUN);

  sat_counter #(.W(CYC_W)) u_run_ctr (
    .clk   (CLK),
    .rst_n (reset_n),
    .clr   (run_clr),
    .en    (run_en),
    .cnt   (run_cnt)
  );

`ifdef PROG_SEQ_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            wd_fire_q,  wd_fire_d;
  logic            timeout_q,  timeout_d;

  sat_counter #(.W(WD_W)) u_wdog_ctr (
    .clk   (CLK),
    .rst_n (reset_n),
    .clr   (run_clr),
    .en    (run_en),
    .cnt   (wd_cnt)
  );

  // This ARM/RUN cycle is the WDOG_LIMIT-th one for the current program.
  assign wd_expire = run_en && (wd_cnt == WD_W'(WDOG_LIMIT - 1));
`endif

  always_comb begin
    state_d      = state_q;
    hold_ct_d    = hold_ct_q;
    prog_sel_d   = prog_sel_q;
    done_flags_d = done_flags_q;
    cycle_cts_d  = cycle_cts_q;
    run_clr      = 1'b0;
`ifdef PROG_SEQ_WDOG_EN
    wd_fire_d    = wd_fire_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d      = LAUNCH;
          prog_sel_d   = '0;
          hold_ct_d    = '0;
          done_flags_d = '0;
          cycle_cts_d  = '0;
`ifdef PROG_SEQ_WDOG_EN
          timeout_d    = 1'b0;
`endif
        end
      end

      LAUNCH: begin
        // Any cpu_halt here is left over from the previous program.
        if (hold_ct_q == HOLD_W'(START_HOLD - 1)) begin
          state_d   = ARM;
          hold_ct_d = '0;
        end else begin
          hold_ct_d = hold_ct_q + 1'b1;
        end
      end

      ARM: begin
        if (!cpu_halt) begin
          state_d = RUN;
        end
`ifdef PROG_SEQ_WDOG_EN
        if (wd_expire) begin
          state_d   = RECORD;
          wd_fire_d = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end

      RUN: begin
        if (cpu_halt) begin
          state_d = RECORD;
        end
`ifdef PROG_SEQ_WDOG_EN
        // A genuine halt on the limit cycle still counts as a completion.
        else if (wd_expire) begin
          state_d   = RECORD;
          wd_fire_d = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end

      RECORD: begin
        cycle_cts_d[int'(prog_sel_q) * int'(CYC_W) +: CYC_W] = run_cnt;
        run_clr = 1'b1;
`ifdef PROG_SEQ_WDOG_EN
        if (!wd_fire_q) begin
          done_flags_d[prog_sel_q] = 1'b1;
        end
        wd_fire_d = 1'b0;
`else
        done_flags_d[prog_sel_q] = 1'b1;
`endif
        if (prog_sel_q == PS_W'(NUM_PROGS - 1)) begin
          state_d = DONE;
        end else begin
          prog_sel_d = prog_sel_q + 1'b1;
          state_d    = LAUNCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they line
    // up with the state they describe.
    cpu_start_d = (state_d == LAUNCH);
    busy_d      = seq_is_busy(state_d);
    all_done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_ct_q    <= '0;
      prog_sel_q   <= '0;
      done_flags_q <= '0;
      cycle_cts_q  <= '0;
      cpu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_ct_q    <= hold_ct_d;
      prog_sel_q   <= prog_sel_d;
      done_flags_q <= done_flags_d;
      cycle_cts_q  <= cycle_cts_d;
      cpu_start_q  <= cpu_start_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
    end
  end

`ifdef PROG_SEQ_WDOG_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wd_fire_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wd_fire_q <= wd_fire_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign cpu_start  = cpu_start_q;
  assign prog_sel   = prog_sel_q;
  assign busy       = busy_q;
  assign done_flags = done_flags_q;
  assign all_done   = all_done_q;
  assign cycle_cts  = cycle_cts_q;

endmodule
